// File: rtl/fp_accumulator.sv
// Streaming binary32 accumulator around a truncating add_sub core.
// Define FP_ACC_SAT_EN to saturate arithmetic overflow to max finite instead of infinity.

module add_sub (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] y
);
    logic        b_sign, swap, eff_sub, rs, sticky;
    logic [7:0]  ex, ez, d, ry;
    logic [23:0] mx, mz;
    logic [26:0] mz_ext, mz_sh, norm;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [22:0] rf;
    logic        unused_bits;

    assign b_sign  = b[31] ^ sub;
    assign swap    = b[30:0] > a[30:0];
    assign ex      = swap ? b[30:23] : a[30:23];
    assign ez      = swap ? a[30:23] : b[30:23];
    assign mx      = {1'b1, swap ? b[22:0] : a[22:0]};
    assign mz      = {1'b1, swap ? a[22:0] : b[22:0]};
    assign rs      = swap ? b_sign : a[31];
    assign eff_sub = a[31] ^ b_sign;
    assign d       = ex - ez;
    assign mz_ext  = {mz, 3'b000};

    // Guard/round/sticky keep the truncated result identical to truncating the exact sum.
    always_comb begin
        sticky = |(mz_ext & ~({27{1'b1}} << d));
        mz_sh  = (mz_ext >> d) | {26'd0, sticky};
        sum    = eff_sub ? ({1'b0, mx, 3'b000} - {1'b0, mz_sh})
                         : ({1'b0, mx, 3'b000} + {1'b0, mz_sh});
    end

    always_comb begin
        lz = 5'd0;
        for (int i = 0; i <= 26; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end
        norm = sum[26:0] << lz;
        if (sum[27]) begin
            ry = ex + 8'd1;
            rf = sum[26:4];
        end else begin
            ry = ex - {3'b000, lz};
            rf = norm[25:3];
        end
        y = {rs, ry, rf};
    end

    assign unused_bits = ^{norm[26], norm[2:0]};
endmodule

module fp_accumulator #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic [2:0]       out_flags
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
`ifdef FP_ACC_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    logic [1:0]       state;
    logic [31:0]      acc, acc_next, sum, s_op;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       flags, flags_next;
    logic [7:0]       op_exp, acc_exp, sum_exp, big_exp;
    logic             take, eff_sub;

    add_sub u_add_sub (.a(acc), .b(in_data), .sub(in_sub), .y(sum));

    assign in_ready = (state != HOLD);
    assign take     = in_valid && in_ready;
    assign op_exp   = in_data[30:23];
    assign acc_exp  = acc[30:23];
    assign sum_exp  = sum[30:23];
    assign big_exp  = (acc_exp > op_exp) ? acc_exp : op_exp;
    assign s_op     = {in_data[31] ^ in_sub, in_data[30:0]};
    assign eff_sub  = acc[31] ^ in_data[31] ^ in_sub;

    // Special operands are resolved here; add_sub only ever sees two normal values.
    always_comb begin
        acc_next   = acc;
        flags_next = flags;
        cnt_next   = (cnt == '1) ? cnt : cnt + 1'b1;
        if (state == IDLE) begin
            cnt_next   = CNT_W'(1);
            flags_next = 3'b000;
            if (op_exp == 8'h00) begin
                acc_next      = 32'd0;
                flags_next[2] = 1'b1;
            end else begin
                acc_next = s_op;
                if (op_exp == 8'hFF) flags_next[1] = 1'b1;
            end
        end else if (op_exp == 8'h00) begin
            flags_next[2] = 1'b1;
        end else if (op_exp == 8'hFF) begin
            acc_next      = s_op;
            flags_next[1] = 1'b1;
        end else if (acc_exp == 8'hFF) begin
            acc_next = acc;
        end else if (acc_exp == 8'h00) begin
            acc_next = s_op;
        end else if (eff_sub && (acc[30:0] == in_data[30:0])) begin
            acc_next      = 32'd0;
            flags_next[0] = 1'b1;
        end else if (!eff_sub && ((sum_exp == 8'hFF) || (sum_exp < big_exp))) begin
            flags_next[1] = 1'b1;
            acc_next      = SAT_EN ? {acc[31], 31'h7F7FFFFF} : {acc[31], 8'hFF, 23'd0};
        end else begin
            acc_next = sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= 32'd0;
            cnt       <= '0;
            flags     <= 3'b000;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_count <= '0;
            out_flags <= 3'b000;
        end else if (state == HOLD) begin
            if (out_ready) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end
        end else if (take) begin
            acc   <= acc_next;
            cnt   <= cnt_next;
            flags <= flags_next;
            if (in_last) begin
                state     <= HOLD;
                out_valid <= 1'b1;
                out_data  <= acc_next;
                out_count <= cnt_next;
                out_flags <= flags_next;
            end else begin
                state <= ACCUM;
            end
        end
    end
endmodule
